// File: rtl/up_pkg.sv
// Shared definitions for the 8-bit microprocessor datapath: widths, opcodes,
// register selects and the execute-stage state encoding.
package up_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_SEL_W  = 2;
   localparam int unsigned DEF_OP_W   = 4;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SHL = 4'd5;
   localparam logic [3:0] OP_SHR = 4'd6;
   localparam logic [3:0] OP_MOV = 4'd7;
   localparam logic [3:0] OP_LDI = 4'd8;
   localparam logic [3:0] OP_MUL = 4'd9;
   localparam logic [3:0] OP_CMP = 4'd10;
   localparam logic [3:0] OP_NOP = 4'd15;

   localparam logic [1:0] SEL_0 = 2'd0;
   localparam logic [1:0] SEL_1 = 2'd1;
   localparam logic [1:0] SEL_2 = 2'd2;
   localparam logic [1:0] SEL_3 = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_WB   = 2'd2
   } state_t;

endpackage

// File: rtl/up_exec_stage_if.sv
// Issue handshake from decode plus the register-file read/write ports
// driven by the execute stage.
interface up_exec_stage_if #(
   parameter int unsigned DATA_W = up_pkg::DEF_DATA_W,
   parameter int unsigned SEL_W  = up_pkg::DEF_SEL_W,
   parameter int unsigned OP_W   = up_pkg::DEF_OP_W
);
   logic              issue_valid;
   logic              issue_ready;
   logic [OP_W-1:0]   issue_op;
   logic [SEL_W-1:0]  issue_rd;
   logic [SEL_W-1:0]  issue_ra;
   logic [SEL_W-1:0]  issue_rb;
   logic [DATA_W-1:0] issue_imm;
   logic [SEL_W-1:0]  rd_sel_a;
   logic [SEL_W-1:0]  rd_sel_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic              wb_we;
   logic [SEL_W-1:0]  wb_sel;
   logic [DATA_W-1:0] wb_data;

   modport master (
      output issue_valid, issue_op, issue_rd, issue_ra, issue_rb, issue_imm,
      output rd_data_a, rd_data_b,
      input  issue_ready, rd_sel_a, rd_sel_b, wb_we, wb_sel, wb_data
   );

   modport slave (
      input  issue_valid, issue_op, issue_rd, issue_ra, issue_rb, issue_imm,
      input  rd_data_a, rd_data_b,
      output issue_ready, rd_sel_a, rd_sel_b, wb_we, wb_sel, wb_data
   );
endinterface

// File: rtl/up_mul_seq.sv
// Sequential shift-add multiplier: bit 0 is folded in at start, the remaining
// DATA_W-1 bits one per cycle; done pulses once the product is final.
module up_mul_seq #(
   parameter int unsigned DATA_W = up_pkg::DEF_DATA_W
) (
   input  logic                  clk,
   input  logic                  nRst,
   input  logic                  start,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic                  done,
   output logic [2*DATA_W-1:0]   product
);
   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned CNT_W  = $clog2(DATA_W) + 1;

   logic [PROD_W-1:0] mcand;
   logic [DATA_W-1:0] mplier;
   logic [CNT_W-1:0]  cnt;
   logic              run;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         product <= '0;
         mcand   <= '0;
         mplier  <= '0;
         cnt     <= '0;
         run     <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            product <= b[0] ? PROD_W'(a) : '0;
            mcand   <= PROD_W'(a) << 1;
            mplier  <= b >> 1;
            cnt     <= CNT_W'(DATA_W - 1);
            run     <= 1'b1;
         end else if (run) begin
            if (mplier[0]) product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               run  <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/up_exec_stage.sv
// Execute/write-back stage: single-cycle ALU ops and an 8-cycle multiply,
// writing results back to the register file and holding Z/C/N flags.
module up_exec_stage
   import up_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned SEL_W  = DEF_SEL_W,
   parameter int unsigned OP_W   = DEF_OP_W
) (
   input  logic            clk,
   input  logic            nRst,
   up_exec_stage_if.slave  bus,
   output logic            flag_z,
   output logic            flag_c,
   output logic            flag_n,
   output logic            busy
);
   state_t              state;
   logic [SEL_W-1:0]    rd_q;
   logic [DATA_W:0]     alu_c;
   logic                accept_c;
   logic                mul_start_c;
   logic                mul_done;
   logic [2*DATA_W-1:0] mul_prod;

   // Returns {carry/borrow, result}.
   function automatic logic [DATA_W:0] alu(input logic [OP_W-1:0]   op,
                                           input logic [DATA_W-1:0] a,
                                           input logic [DATA_W-1:0] b,
                                           input logic [DATA_W-1:0] imm);
      logic [DATA_W:0] r;
      r = '0;
      case (op)
         OP_W'(OP_ADD):                r = {1'b0, a} + {1'b0, b};
         OP_W'(OP_SUB), OP_W'(OP_CMP): r = {1'b0, a} - {1'b0, b};
         OP_W'(OP_AND):                r = {1'b0, a & b};
         OP_W'(OP_OR):                 r = {1'b0, a | b};
         OP_W'(OP_XOR):                r = {1'b0, a ^ b};
         OP_W'(OP_SHL):                r = {a, 1'b0};
         OP_W'(OP_SHR):                r = {a[0], 1'b0, a[DATA_W-1:1]};
         OP_W'(OP_MOV):                r = {1'b0, a};
         OP_W'(OP_LDI):                r = {1'b0, imm};
         default:                      r = '0;
      endcase
      return r;
   endfunction

   assign bus.rd_sel_a    = bus.issue_ra;
   assign bus.rd_sel_b    = bus.issue_rb;
   assign bus.issue_ready = (state == ST_IDLE);
   assign busy            = (state != ST_IDLE);

   assign alu_c       = alu(bus.issue_op, bus.rd_data_a, bus.rd_data_b, bus.issue_imm);
   assign accept_c    = bus.issue_valid && (state == ST_IDLE);
   assign mul_start_c = accept_c && (bus.issue_op == OP_W'(OP_MUL));

   up_mul_seq #(.DATA_W(DATA_W)) u_mul (
      .clk     (clk),
      .nRst    (nRst),
      .start   (mul_start_c),
      .a       (bus.rd_data_a),
      .b       (bus.rd_data_b),
      .done    (mul_done),
      .product (mul_prod)
   );

   // Results and flags are registered on entry to WB so wb_we is high for exactly the WB cycle.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state       <= ST_IDLE;
         rd_q        <= '0;
         bus.wb_we   <= 1'b0;
         bus.wb_sel  <= SEL_W'(SEL_0);
         bus.wb_data <= '0;
         flag_z      <= 1'b0;
         flag_c      <= 1'b0;
         flag_n      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               bus.wb_we <= 1'b0;
               if (accept_c) begin
                  rd_q <= bus.issue_rd;
                  if (bus.issue_op == OP_W'(OP_MUL)) begin
                     state <= ST_MUL;
                  end else begin
                     state <= ST_WB;
                     if (bus.issue_op <= OP_W'(OP_CMP)) begin
                        flag_z <= (alu_c[DATA_W-1:0] == '0);
                        flag_c <= alu_c[DATA_W];
                        flag_n <= alu_c[DATA_W-1];
                     end
                     if (bus.issue_op < OP_W'(OP_MUL)) begin
                        bus.wb_we   <= 1'b1;
                        bus.wb_sel  <= bus.issue_rd;
                        bus.wb_data <= alu_c[DATA_W-1:0];
                     end
                  end
               end
            end
            ST_MUL: begin
               if (mul_done) begin
                  state       <= ST_WB;
                  bus.wb_we   <= 1'b1;
                  bus.wb_sel  <= rd_q;
                  bus.wb_data <= mul_prod[DATA_W-1:0];
                  flag_z      <= (mul_prod[DATA_W-1:0] == '0);
                  flag_c      <= (mul_prod[2*DATA_W-1:DATA_W] != '0);
                  flag_n      <= mul_prod[DATA_W-1];
               end
            end
            ST_WB: begin
               bus.wb_we <= 1'b0;
               state     <= ST_IDLE;
            end
            default: begin
               bus.wb_we <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_up_exec_stage.sv
// Directed bench: execute stage paired with a 4x8 register file model
// whose reset contents are r0..r3 = 1,2,3,4.
module tb_up_exec_stage;
   import up_pkg::*;

   logic clk = 1'b0;
   logic nRst = 1'b0;
   logic fz, fc, fn, busy;
   logic [7:0] rf [4];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   up_exec_stage_if bus ();

   up_exec_stage dut (
      .clk    (clk),
      .nRst   (nRst),
      .bus    (bus),
      .flag_z (fz),
      .flag_c (fc),
      .flag_n (fn),
      .busy   (busy)
   );

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         rf[0] <= 8'd1;
         rf[1] <= 8'd2;
         rf[2] <= 8'd3;
         rf[3] <= 8'd4;
      end else if (bus.wb_we) begin
         rf[bus.wb_sel] <= bus.wb_data;
      end
   end

   assign bus.rd_data_a = rf[bus.rd_sel_a];
   assign bus.rd_data_b = rf[bus.rd_sel_b];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; sampling and driving happen 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                        input logic [1:0] rb, input logic [7:0] imm);
      bus.issue_op    = op;
      bus.issue_rd    = rd;
      bus.issue_ra    = ra;
      bus.issue_rb    = rb;
      bus.issue_imm   = imm;
      bus.issue_valid = 1'b1;
   endtask

   // Present one instruction for a single edge (stage must be idle).
   task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                        input logic [1:0] rb, input logic [7:0] imm);
      drive(op, rd, ra, rb, imm);
      tick();
      bus.issue_valid = 1'b0;
   endtask

   task automatic chk_wb(input string tag, input logic we, input logic [1:0] sel, input logic [7:0] data);
      chk({tag, " wb_we"},   16'(bus.wb_we),   16'(we));
      chk({tag, " wb_sel"},  16'(bus.wb_sel),  16'(sel));
      chk({tag, " wb_data"}, 16'(bus.wb_data), 16'(data));
   endtask

   task automatic chk_flags(input string tag, input logic [2:0] zcn);
      chk({tag, " flags_zcn"}, 16'({fz, fc, fn}), 16'(zcn));
   endtask

   task automatic chk_rf(input string tag, input logic [31:0] exp);
      chk({tag, " r0"}, 16'(rf[0]), 16'(exp[7:0]));
      chk({tag, " r1"}, 16'(rf[1]), 16'(exp[15:8]));
      chk({tag, " r2"}, 16'(rf[2]), 16'(exp[23:16]));
      chk({tag, " r3"}, 16'(rf[3]), 16'(exp[31:24]));
   endtask

   initial begin
      bus.issue_valid = 1'b0;
      bus.issue_op    = '0;
      bus.issue_rd    = '0;
      bus.issue_ra    = '0;
      bus.issue_rb    = '0;
      bus.issue_imm   = '0;

      // Reset state
      tick();
      tick();
      chk("rst ready", 16'(bus.issue_ready), 16'd1);
      chk("rst busy", 16'(busy), 16'd0);
      chk_wb("rst", 1'b0, 2'd0, 8'h00);
      chk_flags("rst", 3'b000);
      nRst = 1'b1;
      tick();

      // ADD r0 = r2 + r3 = 3 + 4
      issue(OP_ADD, 2'd0, 2'd2, 2'd3, 8'h00);
      chk_wb("add", 1'b1, 2'd0, 8'h07);
      chk_flags("add", 3'b000);
      chk("add ready_wb", 16'(bus.issue_ready), 16'd0);
      chk("add busy_wb", 16'(busy), 16'd1);
      tick();
      chk("add ready_after", 16'(bus.issue_ready), 16'd1);
      chk("add we_after", 16'(bus.wb_we), 16'd0);
      chk("add r0", 16'(rf[0]), 16'h07);

      // Fresh register contents for the SUB case
      nRst = 1'b0;
      tick();
      nRst = 1'b1;
      tick();

      // SUB r1 = r0 - r3 = 1 - 4 -> 0xFD with borrow
      issue(OP_SUB, 2'd1, 2'd0, 2'd3, 8'h00);
      chk_wb("sub", 1'b1, 2'd1, 8'hFD);
      chk_flags("sub", 3'b011);
      chk("sub ready_wb", 16'(bus.issue_ready), 16'd0);
      tick();
      chk("sub ready_after", 16'(bus.issue_ready), 16'd1);

      // NOP: no write, flags keep SUB values, wb outputs hold
      issue(4'd15, 2'd3, 2'd0, 2'd0, 8'h00);
      chk_wb("nop", 1'b0, 2'd1, 8'hFD);
      chk_flags("nop", 3'b011);
      chk("nop busy", 16'(busy), 16'd1);
      tick();
      chk_flags("nop after", 3'b011);
      chk_rf("nop rf", {8'd4, 8'd3, 8'hFD, 8'd1});

      // LDI r2 = 0x10, LDI r3 = 0x20
      issue(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h10);
      chk_wb("ldi2", 1'b1, 2'd2, 8'h10);
      chk_flags("ldi2", 3'b000);
      tick();
      issue(OP_LDI, 2'd3, 2'd0, 2'd0, 8'h20);
      chk_wb("ldi3", 1'b1, 2'd3, 8'h20);
      tick();

      // MUL r0 = 0x10 * 0x20 = 0x0200: low byte 0, high byte nonzero
      issue(OP_MUL, 2'd0, 2'd2, 2'd3, 8'h00);
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("mul busy c%0d", i), 16'(busy), 16'd1);
         chk($sformatf("mul we c%0d", i), 16'(bus.wb_we), 16'd0);
         tick();
      end
      chk_wb("mul", 1'b1, 2'd0, 8'h00);
      chk_flags("mul", 3'b110);
      chk("mul busy_wb", 16'(busy), 16'd1);
      tick();
      chk("mul ready_after", 16'(bus.issue_ready), 16'd1);
      chk_rf("mul rf", {8'h20, 8'h10, 8'hFD, 8'h00});

      // Back-pressure: CMP held valid during the ADD's WB cycle
      drive(OP_ADD, 2'd1, 2'd2, 2'd3, 8'h00);
      tick();
      drive(OP_CMP, 2'd3, 2'd0, 2'd0, 8'h00);
      chk_wb("bp add", 1'b1, 2'd1, 8'h30);
      chk_flags("bp add", 3'b000);
      chk("bp ready_wb", 16'(bus.issue_ready), 16'd0);
      tick();
      chk("bp idle ready", 16'(bus.issue_ready), 16'd1);
      chk("bp not_taken busy", 16'(busy), 16'd0);
      chk_flags("bp not_taken", 3'b000);
      tick();
      bus.issue_valid = 1'b0;
      chk_wb("bp cmp", 1'b0, 2'd1, 8'h30);
      chk_flags("bp cmp", 3'b100);
      chk("bp cmp busy", 16'(busy), 16'd1);
      tick();
      chk_rf("bp rf", {8'h20, 8'h10, 8'h30, 8'h00});

      // Reset in MUL cycle 4 aborts the write
      issue(OP_MUL, 2'd0, 2'd2, 2'd3, 8'h00);
      tick();
      tick();
      tick();
      chk("abort busy_pre", 16'(busy), 16'd1);
      nRst = 1'b0;
      #1;
      chk_flags("abort", 3'b000);
      chk("abort ready", 16'(bus.issue_ready), 16'd1);
      chk_wb("abort", 1'b0, 2'd0, 8'h00);
      chk_rf("abort rf", {8'd4, 8'd3, 8'd2, 8'd1});
      tick();
      nRst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("abort we_quiet %0d", i), 16'(bus.wb_we), 16'd0);
      end
      chk("abort ready_after", 16'(bus.issue_ready), 16'd1);
      chk_rf("abort rf_after", {8'd4, 8'd3, 8'd2, 8'd1});

      // ADD after abort completes normally: 3 + 4
      issue(OP_ADD, 2'd0, 2'd2, 2'd3, 8'h00);
      chk_wb("add2", 1'b1, 2'd0, 8'h07);
      chk_flags("add2", 3'b000);
      tick();
      chk("add2 r0", 16'(rf[0]), 16'h07);

      // SHR r2 = 7 >> 1 = 3, carry from bit 0
      issue(OP_SHR, 2'd2, 2'd0, 2'd0, 8'h00);
      chk_wb("shr", 1'b1, 2'd2, 8'h03);
      chk_flags("shr", 3'b010);
      tick();

      // SHL r1 = 0xFD... use r3=4: 4 << 1 = 8, carry 0
      issue(OP_SHL, 2'd1, 2'd3, 2'd0, 8'h00);
      chk_wb("shl", 1'b1, 2'd1, 8'h08);
      chk_flags("shl", 3'b000);
      tick();

      // XOR r3 = r0 ^ r2 = 7 ^ 3 = 4
      issue(OP_XOR, 2'd3, 2'd0, 2'd2, 8'h00);
      chk_wb("xor", 1'b1, 2'd3, 8'h04);
      tick();

      // ADD with carry out and zero result: LDI r1=0xFF, then 0xFF + 1... r1 + r? uses r0=7
      issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'hF9);
      tick();
      issue(OP_ADD, 2'd2, 2'd1, 2'd0, 8'h00);
      chk_wb("add carry", 1'b1, 2'd2, 8'h00);
      chk_flags("add carry", 3'b110);
      tick();
      chk_rf("final rf", {8'h04, 8'h00, 8'hF9, 8'h07});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
